cut_sequencer: RTL and testbench

CUT_SEQUENCER -- requirements
Module: cut_sequencer

---
 rtl/cut_sequencer_pkg.sv | 16 +
 rtl/cut_sequencer_if.sv | 29 ++
 rtl/cut_sequencer_seq_timer.sv | 26 ++
 rtl/cut_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cut_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cut_sequencer_pkg.sv
// Shared definitions for the cut sequencer: state encoding and timing defaults.
package cut_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FEED   = 3'd1,
    CUT    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int CUT_CYCLES_DEF    = 2;
  localparam int SETTLE_CYCLES_DEF = 1;
  localparam int CNT_W             = 4;

endpackage

// File: rtl/cut_sequencer_if.sv
// Job control and status bundle between a controller (master) and the sequencer (slave).
interface cut_sequencer_if;
  import cut_sequencer_pkg::*;

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] len0;
  logic [CNT_W-1:0] len1;
  logic [CNT_W-1:0] len2;
  logic [1:0]       nol;
  logic             feed_en;
  logic             cut;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [1:0]       layer_idx;
  logic [CNT_W-1:0] feed_cnt;

  modport master (
    output start, abort, len0, len1, len2, nol,
    input  feed_en, cut, busy, done, aborted, layer_idx, feed_cnt
  );

  modport slave (
    input  start, abort, len0, len1, len2, nol,
    output feed_en, cut, busy, done, aborted, layer_idx, feed_cnt
  );

endinterface

// File: rtl/cut_sequencer_seq_timer.sv
// Small up-counter with synchronous clear (dominant) and count enable.
module seq_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cut_sequencer.sv
// Feed/cut/settle sequencer for up to three layers per job, with abort support.
module cut_sequencer
  import cut_sequencer_pkg::*;
#(
  parameter int CUT_CYCLES    = CUT_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic            CLK,
  input  logic            CLR,
  cut_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CUT_LAST    = CNT_W'(CUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_len [0:2];
  logic [1:0]       r_nol;
  logic [1:0]       r_layer;
  logic             r_aborted;

  logic             w_start_ok;
  logic [CNT_W-1:0] w_len_sel;
  logic             w_last_layer;
  logic             w_feed_en;
  logic [CNT_W-1:0] w_feed_cnt;
  logic [CNT_W-1:0] w_phase_cnt;
  logic             w_feed_clr;
  logic             w_phase_clr;
  logic             w_phase_en;
  logic             w_layer_inc;
  logic             w_abort_set;

  logic [1:0]       w_tmr_clr;
  logic [1:0]       w_tmr_en;
  logic [CNT_W-1:0] w_tmr_cnt [0:1];

  // abort in IDLE suppresses a simultaneous start
  assign w_start_ok   = (r_state == IDLE) && bus.start && !bus.abort;
  assign w_last_layer = (r_layer == (r_nol - 2'd1));

  always_comb begin
    case (r_layer)
      2'd0:    w_len_sel = r_len[0];
      2'd1:    w_len_sel = r_len[1];
      default: w_len_sel = r_len[2];
    endcase
  end

  assign w_feed_en = (r_state == FEED) && (w_feed_cnt != w_len_sel);

  // timer 0 counts feed cycles, timer 1 paces the CUT and SETTLE phases
  assign w_tmr_clr   = {w_phase_clr, w_feed_clr};
  assign w_tmr_en    = {w_phase_en, w_feed_en};
  assign w_feed_cnt  = w_tmr_cnt[0];
  assign w_phase_cnt = w_tmr_cnt[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_tmr
      seq_timer #(.W(CNT_W)) u_tmr (
        .CLK   (CLK),
        .CLR   (CLR),
        .i_clr (w_tmr_clr[gi]),
        .i_en  (w_tmr_en[gi]),
        .o_cnt (w_tmr_cnt[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_feed_clr   = 1'b0;
    w_phase_clr  = 1'b0;
    w_phase_en   = 1'b0;
    w_layer_inc  = 1'b0;
    w_abort_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_feed_clr   = 1'b1;
          w_state_next = (bus.nol == 2'd0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (bus.abort) begin
          w_abort_set  = 1'b1;
          w_state_next = IDLE;
        end else if (w_feed_cnt == w_len_sel) begin
          w_phase_clr  = 1'b1;
          w_state_next = CUT;
        end
      end
      CUT: begin
        w_phase_en = 1'b1;
        if (bus.abort) begin
          w_abort_set  = 1'b1;
          w_state_next = IDLE;
        end else if (w_phase_cnt == CUT_LAST) begin
          w_phase_clr = 1'b1;
          if (w_last_layer) begin
            w_state_next = DONE;
          end else begin
            w_layer_inc  = 1'b1;
            w_feed_clr   = 1'b1;
            w_state_next = SETTLE;
          end
        end
      end
      SETTLE: begin
        w_phase_en = 1'b1;
        if (bus.abort) begin
          w_abort_set  = 1'b1;
          w_state_next = IDLE;
        end else if (w_phase_cnt == SETTLE_LAST) begin
          w_phase_clr  = 1'b1;
          w_state_next = FEED;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < 3; i++) r_len[i] <= '0;
      r_nol     <= 2'd0;
      r_layer   <= 2'd0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort_set;
      if (w_start_ok) begin
        r_len[0] <= bus.len0;
        r_len[1] <= bus.len1;
        r_len[2] <= bus.len2;
        r_nol    <= bus.nol;
        r_layer  <= 2'd0;
      end else if (w_layer_inc) begin
        r_layer  <= r_layer + 2'd1;
      end
    end
  end

  assign bus.feed_en   = w_feed_en;
  assign bus.cut       = (r_state == CUT);
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.aborted   = (r_state == IDLE) && r_aborted;
  assign bus.layer_idx = r_layer;
  assign bus.feed_cnt  = w_feed_cnt;

endmodule

// File: tb/tb_cut_sequencer.sv
// Directed bench for cut_sequencer: job profiles, abort, input shielding and async reset.
module tb_cut_sequencer;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cut_sequencer_if bus();

  cut_sequencer dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int busy_n, feed_n, bursts, cut_n, cutp, done_n, ab_n, ovl, done_layer;
  int blen [0:3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Pulses start, then observes 40 cycles; disturb_at>=0 rewrites len1/nol and re-pulses start.
  task automatic run_job(input int disturb_at);
    logic prev_fe, prev_cut;
    busy_n = 0; feed_n = 0; bursts = 0; cut_n = 0; cutp = 0;
    done_n = 0; ab_n = 0; ovl = 0; done_layer = -1;
    for (int k = 0; k < 4; k++) blen[k] = 0;
    prev_fe = 1'b0; prev_cut = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_n++;
      if (bus.feed_en) begin
        feed_n++;
        if (!prev_fe) bursts++;
        if (bursts >= 1 && bursts <= 4) blen[bursts-1]++;
      end
      if (bus.cut) begin
        cut_n++;
        if (!prev_cut) cutp++;
      end
      if (bus.done) begin
        done_n++;
        done_layer = int'(bus.layer_idx);
      end
      if (bus.aborted) ab_n++;
      if (bus.feed_en && bus.cut) ovl++;
      prev_fe  = bus.feed_en;
      prev_cut = bus.cut;
      if (i == disturb_at) begin
        bus.len1  = 4'd9;
        bus.nol   = 2'd3;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      cyc();
    end
    $display("job: busy=%0d feed=%0d bursts=%0d cut=%0d cutpulses=%0d done=%0d aborted=%0d",
             busy_n, feed_n, bursts, cut_n, cutp, done_n, ab_n);
  endtask

  initial begin
    int found;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.len0 = 4'd0; bus.len1 = 4'd0; bus.len2 = 4'd0; bus.nol = 2'd0;

    @(negedge CLK);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_feed_en", 32'(bus.feed_en), 0);
    chk("rst_cut", 32'(bus.cut), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_aborted", 32'(bus.aborted), 0);
    chk("rst_layer", 32'(bus.layer_idx), 0);
    chk("rst_feed_cnt", 32'(bus.feed_cnt), 0);
    $display("reset: busy=%0d feed_cnt=%0d", bus.busy, bus.feed_cnt);
    CLR = 1'b1;
    cyc();

    // three layers of 1,2,3 feed cycles
    bus.len0 = 4'd1; bus.len1 = 4'd2; bus.len2 = 4'd3; bus.nol = 2'd3;
    run_job(-1);
    chk("j3_busy", 32'(busy_n), 18);
    chk("j3_feed", 32'(feed_n), 6);
    chk("j3_bursts", 32'(bursts), 3);
    chk("j3_blen0", 32'(blen[0]), 1);
    chk("j3_blen1", 32'(blen[1]), 2);
    chk("j3_blen2", 32'(blen[2]), 3);
    chk("j3_cut", 32'(cut_n), 6);
    chk("j3_cutpulses", 32'(cutp), 3);
    chk("j3_done", 32'(done_n), 1);
    chk("j3_done_layer", 32'(done_layer), 2);
    chk("j3_aborted", 32'(ab_n), 0);
    chk("j3_overlap", 32'(ovl), 0);

    // single layer of zero length
    bus.len0 = 4'd0; bus.nol = 2'd1;
    run_job(-1);
    chk("j1z_busy", 32'(busy_n), 4);
    chk("j1z_feed", 32'(feed_n), 0);
    chk("j1z_cut", 32'(cut_n), 2);
    chk("j1z_done", 32'(done_n), 1);

    // zero layers
    bus.nol = 2'd0;
    run_job(-1);
    chk("j0_busy", 32'(busy_n), 1);
    chk("j0_feed", 32'(feed_n), 0);
    chk("j0_cut", 32'(cut_n), 0);
    chk("j0_done", 32'(done_n), 1);

    // abort together with start in IDLE
    bus.nol = 2'd1; bus.start = 1'b1; bus.abort = 1'b1;
    cyc();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("idle_abort_busy", 32'(bus.busy), 0);
    chk("idle_abort_pulse", 32'(bus.aborted), 0);
    $display("idle abort+start: busy=%0d aborted=%0d", bus.busy, bus.aborted);
    cyc();

    // abort during a long feed at feed_cnt=7
    bus.len0 = 4'd15; bus.nol = 2'd2; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (bus.feed_cnt == 4'd7) found = 1;
      else cyc();
    end
    chk("abort_wait", 32'(found), 1);
    chk("abort_pre_feed_en", 32'(bus.feed_en), 1);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    chk("abort_feed_en", 32'(bus.feed_en), 0);
    chk("abort_pulse", 32'(bus.aborted), 1);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    $display("abort: feed_en=%0d aborted=%0d busy=%0d", bus.feed_en, bus.aborted, bus.busy);
    cyc();
    chk("abort_pulse_end", 32'(bus.aborted), 0);
    chk("abort_idle", 32'(bus.busy), 0);
    chk("abort_no_done", 32'(bus.done), 0);

    // inputs changed and start re-pulsed while busy
    bus.len0 = 4'd1; bus.len1 = 4'd2; bus.len2 = 4'd3; bus.nol = 2'd2;
    run_job(3);
    chk("shield_busy", 32'(busy_n), 11);
    chk("shield_feed", 32'(feed_n), 3);
    chk("shield_blen1", 32'(blen[1]), 2);
    chk("shield_cut", 32'(cut_n), 4);
    chk("shield_done", 32'(done_n), 1);

    // asynchronous reset in the middle of CUT
    bus.len0 = 4'd1; bus.nol = 2'd1; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    chk("mid_cut_active", 32'(bus.cut), 1);
    #2 CLR = 1'b0;
    #1;
    chk("clr_cut", 32'(bus.cut), 0);
    chk("clr_busy", 32'(bus.busy), 0);
    chk("clr_feed_en", 32'(bus.feed_en), 0);
    $display("async clr: cut=%0d busy=%0d feed_en=%0d", bus.cut, bus.busy, bus.feed_en);
    @(negedge CLK);
    CLR = 1'b1;
    busy_n = 0; done_n = 0; ab_n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      if (bus.aborted) ab_n++;
    end
    chk("post_clr_busy", 32'(busy_n), 0);
    chk("post_clr_done", 32'(done_n), 0);
    chk("post_clr_aborted", 32'(ab_n), 0);
    chk("post_clr_feed_cnt", 32'(bus.feed_cnt), 0);
    chk("post_clr_layer", 32'(bus.layer_idx), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
